sram_responder: RTL and testbench

//  Synthesizable responder for the SLC-3 external SRAM bus (1Mx16, active-low CE/UB/LB/OE/WE,
//  20-bit ADDR, bidirectional 16-bit Data). Answers the CPU's Mem2IO initiator in place of the

---
 rtl/sram_responder.sv | 241 ++++++++++++++++++++++++
 tb/tb_sram_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: on-chip stand-in for the SLC-3 1Mx16 external SRAM.
// Answers Mem2IO bus cycles from a local word array with a programmable read latency,
// byte-lane enables and commit-on-WE-rise writes. A loader port fills the array while
// the bus is idle (CE high).
// Optional feature: define SRAM_ACCESS_COUNT_EN to add saturating rd_count/wr_count outputs.
module sram_responder #(
   parameter int unsigned MEM_AW   = 10,
   parameter int unsigned READ_LAT = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              CE,
   input  logic              UB,
   input  logic              LB,
   input  logic              OE,
   input  logic              WE,
   input  logic [19:0]       ADDR,
   inout  wire  [15:0]       Data,
   input  logic              ld_en,
   input  logic [MEM_AW-1:0] ld_addr,
   input  logic [15:0]       ld_data,
   output logic              rd_valid,
   output logic              addr_err
`ifdef SRAM_ACCESS_COUNT_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);

   localparam int unsigned Depth  = 2 ** MEM_AW;
   localparam logic [3:0]  LatMax = 4'(READ_LAT);

   typedef enum logic [1:0] {
      StIdle,
      StRdWait,
      StRdDrive,
      StWrHold
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        lat_cnt_q, lat_cnt_d;
   logic [19:0]       rd_addr_q, rd_addr_d;
   logic [19:0]       wr_addr_q, wr_addr_d;
   logic [15:0]       wr_data_q, wr_data_d;
   // Sampled lane enables, kept active-low like the bus pins.
   logic              wr_ub_q, wr_ub_d;
   logic              wr_lb_q, wr_lb_d;
   logic              addr_err_q, addr_err_d;

   logic [15:0]       mem_q [Depth];

   logic              rd_req;
   logic              wr_act;
   logic              addr_same;
   logic              req_oor;
   logic              rd_oor;
   logic              wr_oor;
   logic              latch_rd;
   logic              rd_done;
   logic              commit_try;
   logic              commit_any;
   logic              commit_ok;
   logic              ld_ok;
   logic [MEM_AW-1:0] mem_waddr;
   logic [15:0]       mem_wdata;
   logic              mem_we_hi;
   logic              mem_we_lo;
   logic [15:0]       rd_word;

   // Bus request decode; WE overrides OE so a write never looks like a read.
   assign rd_req    = !CE && !OE && WE;
   assign wr_act    = !CE && !WE;
   assign addr_same = (ADDR == rd_addr_q);
   assign req_oor   = (ADDR >> MEM_AW) != 20'd0;
   assign rd_oor    = (rd_addr_q >> MEM_AW) != 20'd0;
   assign wr_oor    = (wr_addr_q >> MEM_AW) != 20'd0;

   // Next-state logic: request tracking, latency count and write sampling.
   always_comb begin
      state_d    = state_q;
      lat_cnt_d  = lat_cnt_q;
      rd_addr_d  = rd_addr_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_ub_d    = wr_ub_q;
      wr_lb_d    = wr_lb_q;
      latch_rd   = 1'b0;
      rd_done    = 1'b0;
      commit_try = 1'b0;

      // Every cycle with an active write refreshes the sample, whatever the state.
      if (wr_act) begin
         wr_addr_d = ADDR;
         wr_data_d = Data;
         wr_ub_d   = UB;
         wr_lb_d   = LB;
      end

      unique case (state_q)
         StIdle: begin
            if (wr_act) begin
               state_d = StWrHold;
            end else if (rd_req) begin
               latch_rd = 1'b1;
            end
         end
         StRdWait: begin
            if (wr_act) begin
               state_d = StWrHold;
            end else if (!rd_req) begin
               state_d = StIdle;
            end else if (!addr_same) begin
               latch_rd = 1'b1;
            end else if (lat_cnt_q == LatMax) begin
               state_d = StRdDrive;
               rd_done = 1'b1;
            end else begin
               lat_cnt_d = lat_cnt_q + 4'd1;
            end
         end
         StRdDrive: begin
            if (wr_act) begin
               state_d = StWrHold;
            end else if (!rd_req) begin
               state_d = StIdle;
            end else if (!addr_same) begin
               latch_rd = 1'b1;
            end
         end
         StWrHold: begin
            if (!wr_act) begin
               commit_try = 1'b1;
               if (rd_req) begin
                  latch_rd = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Any (re)start of a read restarts the latency count on the new address.
      if (latch_rd) begin
         state_d   = StRdWait;
         lat_cnt_d = 4'd1;
         rd_addr_d = ADDR;
      end
   end

   // A commit needs at least one lane; a reset in the same cycle discards it.
   assign commit_any = commit_try && !Reset && (!wr_ub_q || !wr_lb_q);
   assign commit_ok  = commit_any && !wr_oor;
   // The loader yields to the CPU in the cycle CE rises out of a write.
   assign ld_ok      = ld_en && CE && !commit_try;
   assign addr_err_d = (latch_rd && req_oor) || (commit_any && wr_oor);

   // Single array write port shared by CPU commits and the loader.
   always_comb begin
      mem_waddr = ld_addr;
      mem_wdata = ld_data;
      mem_we_hi = ld_ok;
      mem_we_lo = ld_ok;
      if (commit_ok) begin
         mem_waddr = wr_addr_q[MEM_AW-1:0];
         mem_wdata = wr_data_q;
         mem_we_hi = !wr_ub_q;
         mem_we_lo = !wr_lb_q;
      end
   end

   // State and sample registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= StIdle;
         lat_cnt_q  <= 4'd0;
         rd_addr_q  <= 20'd0;
         wr_addr_q  <= 20'd0;
         wr_data_q  <= 16'd0;
         wr_ub_q    <= 1'b1;
         wr_lb_q    <= 1'b1;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lat_cnt_q  <= lat_cnt_d;
         rd_addr_q  <= rd_addr_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_ub_q    <= wr_ub_d;
         wr_lb_q    <= wr_lb_d;
         addr_err_q <= addr_err_d;
      end
   end

   // Word array with per-byte write enables; contents survive reset.
   always_ff @(posedge Clk) begin
      if (mem_we_hi) begin
         mem_q[mem_waddr][15:8] <= mem_wdata[15:8];
      end
      if (mem_we_lo) begin
         mem_q[mem_waddr][7:0] <= mem_wdata[7:0];
      end
   end

   // Data is valid from the cycle the count reaches READ_LAT, as long as the request holds.
   assign rd_valid = rd_req && addr_same &&
                     ((state_q == StRdDrive) || ((state_q == StRdWait) && (lat_cnt_q == LatMax)));
   assign rd_word  = rd_oor ? 16'h0000 : mem_q[rd_addr_q[MEM_AW-1:0]];
   assign addr_err = addr_err_q;

   assign Data[15:8] = (rd_valid && !UB) ? rd_word[15:8] : 8'hzz;
   assign Data[7:0]  = (rd_valid && !LB) ? rd_word[7:0]  : 8'hzz;

`ifdef SRAM_ACCESS_COUNT_EN
   logic [15:0] rd_count_q;
   logic [15:0] wr_count_q;

   // Saturating access counters; loader traffic is not counted.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rd_count_q <= 16'd0;
         wr_count_q <= 16'd0;
      end else begin
         if (rd_done && (rd_count_q != 16'hFFFF)) begin
            rd_count_q <= rd_count_q + 16'd1;
         end
         if (commit_ok && (wr_count_q != 16'hFFFF)) begin
            wr_count_q <= wr_count_q + 16'd1;
         end
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`else
   logic unused_cnt;
   assign unused_cnt = rd_done;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Randomised bench for sram_responder against a cycle-level behavioural model:
// reads become valid once a request has been stable for READ_LAT+1 cycles, writes land
// when WE/CE rises, the loader fills the array while CE is high.
module tb_sram_responder;

   localparam int unsigned MEM_AW   = 10;
   localparam int unsigned READ_LAT = 2;
   localparam int unsigned Depth    = 2 ** MEM_AW;

   logic              clk;
   logic              rst;
   logic              ce, ub, lb, oe, we;
   logic [19:0]       addr;
   logic [15:0]       tb_dout;
   logic              ld_en;
   logic [MEM_AW-1:0] ld_addr;
   logic [15:0]       ld_data;
   logic              rd_valid;
   logic              addr_err;
   wire  [15:0]       data_w;
`ifdef SRAM_ACCESS_COUNT_EN
   logic [15:0]       rd_count;
   logic [15:0]       wr_count;
`endif

   // The bench owns the bus whenever WE is low.
   assign data_w = (!we) ? tb_dout : 16'hzzzz;

   sram_responder #(
      .MEM_AW   (MEM_AW),
      .READ_LAT (READ_LAT)
   ) dut (
      .Clk      (clk),
      .Reset    (rst),
      .CE       (ce),
      .UB       (ub),
      .LB       (lb),
      .OE       (oe),
      .WE       (we),
      .ADDR     (addr),
      .Data     (data_w),
      .ld_en    (ld_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .rd_valid (rd_valid),
      .addr_err (addr_err)
`ifdef SRAM_ACCESS_COUNT_EN
      ,
      .rd_count (rd_count),
      .wr_count (wr_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;

   // Behavioural model state.
   logic [15:0] mdl [Depth];
   int          run      = 0;
   bit          prev_rd  = 1'b0;
   logic [19:0] prev_addr = '0;
   bit          prev_rst = 1'b1;
   bit          wr_hold  = 1'b0;
   logic [19:0] s_addr   = '0;
   logic [15:0] s_data   = '0;
   bit          s_ub     = 1'b1;
   bit          s_lb     = 1'b1;
   bit          exp_err  = 1'b0;
   int          rdc      = 0;
   int          wrc      = 0;
   bit          armed    = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit oor(input logic [19:0] a);
      return (a >> MEM_AW) != 20'd0;
   endfunction

   // Wait for the falling edge and compare the outputs with the model.
   task automatic sample();
      bit          rd_req;
      bit          exp_v;
      logic [15:0] mask;
      logic [15:0] expw;
      @(negedge clk);
      rd_req = !ce && !oe && we;
      if (!rd_req) run = 0;
      else if (prev_rst || !prev_rd || addr != prev_addr) run = 1;
      else run = run + 1;
      if (armed) begin
         exp_v = rd_req && (run >= READ_LAT + 1);
         check("rd_valid", {31'd0, rd_valid}, {31'd0, exp_v});
         check("addr_err", {31'd0, addr_err}, {31'd0, exp_err});
         mask = {{8{!ub}}, {8{!lb}}};
         if (exp_v && mask != 16'd0) begin
            expw = oor(addr) ? 16'h0000 : mdl[addr[MEM_AW-1:0]];
            check("rd_data", {16'd0, data_w & mask}, {16'd0, expw & mask});
         end
`ifdef SRAM_ACCESS_COUNT_EN
         check("rd_count", {16'd0, rd_count}, rdc);
         check("wr_count", {16'd0, wr_count}, wrc);
`endif
      end
   endtask

   // Apply this cycle's inputs to the model across the rising edge.
   task automatic advance();
      bit rd_req, wr_act, commit_any, s_oor, nxt_err, ld_blk;
      rd_req     = !ce && !oe && we;
      wr_act     = !ce && !we;
      s_oor      = oor(s_addr);
      ld_blk     = wr_hold && !wr_act;
      commit_any = ld_blk && !rst && (!s_ub || !s_lb);
      nxt_err    = !rst && ((rd_req && run == 1 && oor(addr)) || (commit_any && s_oor));
      @(posedge clk);
      if (commit_any && !s_oor) begin
         if (!s_ub) mdl[s_addr[MEM_AW-1:0]][15:8] = s_data[15:8];
         if (!s_lb) mdl[s_addr[MEM_AW-1:0]][7:0]  = s_data[7:0];
      end else if (ld_en && ce && !ld_blk) begin
         mdl[ld_addr] = ld_data;
      end
      if (rst) begin
         rdc = 0;
         wrc = 0;
      end else begin
         if (rd_req && run == READ_LAT + 1 && rdc != 16'hFFFF) rdc++;
         if (commit_any && !s_oor && wrc != 16'hFFFF) wrc++;
      end
      if (wr_act) begin
         s_addr = addr;
         s_data = tb_dout;
         s_ub   = ub;
         s_lb   = lb;
      end
      wr_hold   = wr_act && !rst;
      prev_rd   = rd_req;
      prev_addr = addr;
      prev_rst  = rst;
      exp_err   = nxt_err;
      if (rst) armed = 1'b1;
      #1;
   endtask

   task automatic tick();
      sample();
      advance();
   endtask

   task automatic bus_idle();
      ce = 1'b1; oe = 1'b1; we = 1'b1; ub = 1'b0; lb = 1'b0; ld_en = 1'b0;
   endtask

   task automatic load(input logic [MEM_AW-1:0] a, input logic [15:0] d);
      bus_idle();
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic set_rd(input logic [19:0] a);
      ce = 1'b0; oe = 1'b0; we = 1'b1; ub = 1'b0; lb = 1'b0; addr = a;
   endtask

   task automatic set_wr(input logic [19:0] a, input logic [15:0] d, input bit u, input bit l);
      ce = 1'b0; oe = 1'b1; we = 1'b0; ub = u; lb = l; addr = a; tb_dout = d;
   endtask

   function automatic logic [19:0] pick_addr();
      case ($urandom_range(0, 6))
         0: return 20'd5;
         1: return 20'd6;
         2: return 20'd7;
         3: return 20'h00400;
         4: return 20'h003FF;
         5: return 20'($urandom_range(0, Depth - 1));
         default: return 20'($urandom);
      endcase
   endfunction

   logic [15:0] m0;
   logic [15:0] m11;

   initial begin
      rst = 1'b1; addr = '0; tb_dout = '0; ld_addr = '0; ld_data = '0;
      bus_idle();
      tick();
      tick();
      rst = 1'b0;
      sample();
      check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("reset_addr_err", {31'd0, addr_err}, 32'd0);
      advance();

      // Fill the array through the loader.
      for (int i = 0; i < Depth; i++) load(MEM_AW'(i), 16'($urandom));
      load(10'd5, 16'h1234);
      load(10'd6, 16'h5A5A);
      load(10'd7, 16'h0000);

      // Read with latency, then change address while driving.
      set_rd(20'd5);
      sample(); check("t1_c1_valid", {31'd0, rd_valid}, 32'd0); advance();
      sample(); check("t1_c2_valid", {31'd0, rd_valid}, 32'd0); advance();
      sample(); check("t1_c3_data", {16'd0, data_w}, 32'h1234); advance();
      addr = 20'd6;
      sample(); check("t3_c0_valid", {31'd0, rd_valid}, 32'd0); advance();
      sample(); check("t3_c1_valid", {31'd0, rd_valid}, 32'd0); advance();
      sample(); check("t3_c2_data", {16'd0, data_w}, 32'h5A5A); advance();
      bus_idle(); tick();

      // Upper-lane write, then read back.
      set_wr(20'd7, 16'hABCD, 1'b0, 1'b1);
      repeat (3) tick();
      set_rd(20'd7);
      tick(); tick();
      sample(); check("t2_data", {16'd0, data_w}, 32'hAB00); advance();
      bus_idle(); tick();

      // OE and WE low together: write wins, bus never driven.
      ce = 1'b0; oe = 1'b0; we = 1'b0; ub = 1'b0; lb = 1'b0; addr = 20'd9; tb_dout = 16'h1111;
      repeat (3) begin
         sample(); check("t4_no_drive", {31'd0, rd_valid}, 32'd0); advance();
      end
      bus_idle(); tick();
      set_rd(20'd9);
      tick(); tick();
      sample(); check("t4_data", {16'd0, data_w}, 32'h1111); advance();
      bus_idle(); tick();

      // Out-of-range read and write.
      m0 = mdl[0];
      set_rd(20'h00400);
      tick();
      sample(); check("t5_rd_err", {31'd0, addr_err}, 32'd1); advance();
      sample(); check("t5_rd_err_once", {31'd0, addr_err}, 32'd0);
      check("t5_rd_zero", {16'd0, data_w}, 32'h0000); advance();
      bus_idle(); tick();
      set_wr(20'h00400, 16'hFFFF, 1'b0, 1'b0);
      tick();
      bus_idle(); tick();
      sample(); check("t5_wr_err", {31'd0, addr_err}, 32'd1); advance();
      set_rd(20'd0);
      tick(); tick();
      sample(); check("t5_no_alias", {16'd0, data_w}, {16'd0, m0}); advance();
      bus_idle(); tick();

      // Reset during a pending write discards it.
      m11 = mdl[11];
      set_wr(20'd11, 16'hBEEF, 1'b0, 1'b0);
      tick(); tick();
      rst = 1'b1; we = 1'b1;
      tick();
      rst = 1'b0; bus_idle();
      tick();
`ifdef SRAM_ACCESS_COUNT_EN
      sample();
      check("t6_rd_count", {16'd0, rd_count}, 32'd0);
      check("t6_wr_count", {16'd0, wr_count}, 32'd0);
      advance();
`endif
      set_rd(20'd11);
      tick(); tick();
      sample(); check("t6_no_commit", {16'd0, data_w}, {16'd0, m11}); advance();
      bus_idle(); tick();

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) >= 6) begin
            ce = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
               0, 1: begin oe = 1'b0; we = 1'b1; end
               2: begin oe = 1'($urandom); we = 1'b0; end
               default: begin oe = 1'b1; we = 1'b1; end
            endcase
            addr = pick_addr();
            ub = ($urandom_range(0, 3) == 0);
            lb = ($urandom_range(0, 3) == 0);
            tb_dout = 16'($urandom);
         end
         ld_en   = ($urandom_range(0, 3) == 0);
         ld_addr = MEM_AW'($urandom);
         ld_data = 16'($urandom);
         rst     = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      bus_idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
